// File: rtl/decrypt_round_core.sv
// Iterative 8-bit Feistel decryption core: one round per accepted key triplet,
// ROUNDS rounds per 16-bit block, result held on pt_out after a one-cycle done pulse.
module decrypt_round_core #(
    parameter int unsigned ROUNDS = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] ct_in,
    input  logic        key_valid,
    input  logic [7:0]  K_A,
    input  logic [7:0]  K_B,
    input  logic [7:0]  K_C,
    output logic        key_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] pt_out
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned HALF_W = 8;
    localparam int unsigned BLK_W  = 2 * HALF_W;
    localparam int unsigned ROT    = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [HALF_W-1:0] l_q;
    logic [HALF_W-1:0] r_q;
    logic [HALF_W-1:0] l_n;
    logic [HALF_W-1:0] r_n;
    logic [IDX_W-1:0]  idx_n;
    logic [BLK_W-1:0]  pt_n;
    logic              key_ready_n;
    logic              busy_n;
    logic              done_n;
    logic [HALF_W-1:0] mix_c;
    logic [HALF_W-1:0] f_c;

    // Round function: rotl3((L ^ K_A) + K_B) ^ K_C, addition wraps mod 256
    always_comb begin
        mix_c = HALF_W'((l_q ^ K_A) + K_B);
        f_c   = {mix_c[HALF_W-ROT-1:0], mix_c[HALF_W-1:HALF_W-ROT]} ^ K_C;
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_n     = state;
        l_n         = l_q;
        r_n         = r_q;
        idx_n       = round_idx;
        pt_n        = pt_out;
        key_ready_n = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    l_n     = ct_in[BLK_W-1:HALF_W];
                    r_n     = ct_in[HALF_W-1:0];
                    idx_n   = '0;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                // key_ready is high for the whole of RUN, so key_valid alone marks a transfer
                if (key_valid) begin
                    l_n = r_q ^ f_c;
                    r_n = l_q;
                    if (round_idx == LAST_IDX) begin
                        pt_n    = {r_q ^ f_c, l_q};
                        state_n = S_DONE;
                    end else begin
                        idx_n = IDX_W'(round_idx + IDX_W'(1));
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        key_ready_n = (state_n == S_RUN);
        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DONE);
    end

    // State, datapath and registered status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            l_q       <= '0;
            r_q       <= '0;
            round_idx <= '0;
            pt_out    <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            l_q       <= l_n;
            r_q       <= r_n;
            round_idx <= idx_n;
            pt_out    <= pt_n;
            key_ready <= key_ready_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule
